// File: rtl/digest_uart_sender.sv
// Return-path serializer: captures a SHA digest and streams it MSB-first as bytes
// (raw) or lowercase ASCII hex plus line feed over an AXI-Stream byte interface.
module digest_uart_sender #(
   parameter int DIGEST_BITS = 512,
   parameter int HEX_ASCII   = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [DIGEST_BITS-1:0] hash,
   input  logic                   out_valid,
   output logic                   busy,
   output logic                   overrun,
   output logic [7:0]             m_axis_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready
);

   localparam int NBYTES = DIGEST_BITS / 8;
   localparam int CW     = $clog2(NBYTES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(NBYTES);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_TERM = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [DIGEST_BITS-1:0] shift_q, shift_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   phase_q, phase_d;
   logic                   busy_q, busy_d;
   logic                   overrun_q, overrun_d;
   logic                   tvalid_q, tvalid_d;
   logic [7:0]             tdata_q, tdata_d;
   logic                   hs_s;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return {4'h3, nib};
      end else begin
         return {4'h0, nib} + 8'h57;
      end
   endfunction

   // Next-state logic; outputs are precomputed from the next state so they can be registered.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      hs_s    = tvalid_q & m_axis_tready;

      case (state_q)
         S_IDLE: begin
            if (out_valid) begin
               state_d = S_SEND;
               shift_d = hash;
               cnt_d   = CNT_LOAD;
               phase_d = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SEND: begin
            if (hs_s) begin
               if ((HEX_ASCII != 0) && phase_q) begin
                  phase_d = 1'b0;
               end else begin
                  shift_d = shift_q << 4'd8;
                  cnt_d   = cnt_q - CNT_ONE;
                  phase_d = 1'b1;
                  if (cnt_q == CNT_ONE) begin
                     state_d = (HEX_ASCII != 0) ? S_TERM : S_IDLE;
                  end else begin
                     state_d = S_SEND;
                  end
               end
            end else begin
               state_d = S_SEND;
            end
         end
         S_TERM: begin
            if (hs_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_TERM;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A strobe outside IDLE (including the final-handshake cycle) is dropped and flagged.
      overrun_d = out_valid & (state_q != S_IDLE);
      tvalid_d  = (state_d != S_IDLE);
      busy_d    = (state_d != S_IDLE);

      case (state_d)
         S_SEND: begin
            if (HEX_ASCII != 0) begin
               tdata_d = hex_char(phase_d ? shift_d[DIGEST_BITS-1 -: 4]
                                          : shift_d[DIGEST_BITS-5 -: 4]);
            end else begin
               tdata_d = shift_d[DIGEST_BITS-1 -: 8];
            end
         end
         S_TERM:  tdata_d = 8'h0A;
         default: tdata_d = 8'h00;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         cnt_q     <= '0;
         phase_q   <= 1'b1;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
         tvalid_q  <= 1'b0;
         tdata_q   <= 8'h00;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         busy_q    <= busy_d;
         overrun_q <= overrun_d;
         tvalid_q  <= tvalid_d;
         tdata_q   <= tdata_d;
      end
   end

   assign busy          = busy_q;
   assign overrun       = overrun_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;

endmodule
